uart_ascii_rx: RTL and testbench
================================

# uart_ascii_rx

UART receiver that turns the serial line from the host terminal into the byte-wide `data`/`valid` stream consumed by the calculator state machine. It synchronises the asynchronous `rx` pin, detects and validates start bits, and samples 8N1 frames LSB-first at mid-bit. Each good frame produces exactly one single-cycle `valid` pulse. Frames with a bad stop bit are flagged on `frame_err` and are never forwarded.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); legal range 4..65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  8  last good received byte (ASCII); held between frames.
- `valid`  out  1  one-cycle pulse; `data` is valid in that cycle.
- `frame_err`  out  1  one-cycle pulse on stop-bit error.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- Synchroniser: two flops `rx` -> `rx_s`, both reset to 1. All FSM decisions use `rx_s` only.
- `HALF = CLKS_PER_BIT/2` (integer division). Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide; `bit_idx` is 3 bits; `shift` is 8 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rx_s==0`, go to START with `cnt<=0`.
  - START: `cnt` increments. At `cnt==HALF-1`:
    - if `rx_s==0`, go to DATA with `cnt<=0` and `bit_idx<=0`;
    - else it was a glitch: return to IDLE with no output.
  - DATA: `cnt` increments. At `cnt==CLKS_PER_BIT-1`:
    - `shift <= {rx_s, shift[7:1]}` (LSB first), `cnt<=0`;
    - if `bit_idx==7`, go to STOP; else `bit_idx++`.
  - STOP: at `cnt==CLKS_PER_BIT-1`:
    - if `rx_s==1`: `data<=shift`, `valid<=1`;
    - else: `frame_err<=1` and `data` is unchanged;
    - in both cases go to IDLE.
- IDLE after a frame error waits for `rx_s` low again. A line held low (break) therefore causes repeated false-start checks, but no `valid` pulse is produced while the line stays low, because every stop sample reads 0.
- No parity and no FIFO. The consumer must accept every `valid` pulse; back-to-back frames are always separated by at least one stop bit, so there is no overrun.

## Timing
- Reset values: `data=8'h00`, `valid=0`, `frame_err=0`, `busy=0`, state IDLE, `cnt=0`, `bit_idx=0`, `shift=0`, sync flops = 1.
- Reset asserted mid-frame: the frame is abandoned. No `valid` or `frame_err` pulse is produced for it, and the next frame after release is received normally.
- Latency:
  - A falling edge on `rx` reaches `rx_s` 2 clocks later.
  - Data bit k (k=0..7) is sampled at `HALF + (k+1)*CLKS_PER_BIT` cycles after IDLE sees `rx_s==0`.
  - The stop bit is sampled at `HALF + 9*CLKS_PER_BIT` cycles after that point.
  - `valid`/`frame_err` is high the cycle after the stop sample and low in the following cycle.
- `busy` goes high the cycle after IDLE sees `rx_s==0` and low in the same cycle `valid`/`frame_err` goes high.
- Leaving STOP at mid-stop-bit means a start bit immediately following the stop bit is detected without loss.
- Tolerated baud mismatch: about ±4% at `CLKS_PER_BIT>=16`.

## Test plan
Bench uses `CLKS_PER_BIT=16` and drives `rx` with an 8N1 task at exactly 16 clocks per bit.
- Send 0x31 ('1'): exactly one `valid` pulse, one cycle wide, with `data==8'h31`; `frame_err` stays 0; `busy` is high for the frame, then low.
- Back-to-back "12+24=" (0x31,0x32,0x2B,0x32,0x34,0x3D), no idle gap between frames: six `valid` pulses carrying exactly those bytes, in order.
- Glitch: `rx` low for 3 cycles, then high: no `valid`, no `frame_err`; FSM back in IDLE within `HALF+3` cycles. A following 0x63 ('c') is received correctly.
- Bad stop: frame 0x2A with stop bit driven 0: one `frame_err` pulse, no `valid`, `data` keeps its previous value. The next good 0x2F is received correctly.
- Reset mid-frame: assert `rst` for 2 cycles during bit 4 of 0x39: no pulse for that frame; all outputs at reset values. The next frame 0x35 gives `data==8'h35`.
- Boundaries: 0x00 and 0xFF are each received exactly. Idle line held high for 1000 cycles gives no pulses.

Source files
------------

// File: rtl/uart_ascii_rx.sv
// uart_ascii_rx
// Receives 8N1 frames from the host terminal and presents each good byte
// as a one-cycle pulse for the calculator state machine.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   data       last good received byte, held between frames
//   valid      one-cycle pulse, data is meaningful in that cycle
//   frame_err  one-cycle pulse when a stop bit reads low
//   busy       high while a frame is in progress (state other than IDLE)
//
// Handshake: data/valid is a push-only stream with no ready. The consumer
// must take data in every cycle valid is high; valid never stays high for
// more than one cycle, and consecutive pulses are at least one bit time apart.
module uart_ascii_rx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            rx_meta;
   logic            rx_s;

   // Two-flop synchroniser; reset to the idle level so a reset never looks
   // like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         shift     <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               cnt <= cnt + 1'b1;
               // Re-check the line at the middle of the start bit; a high
               // level here means the falling edge was only a glitch.
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               cnt <= cnt + 1'b1;
               if (cnt == BIT_M1) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            STOP: begin
               cnt <= cnt + 1'b1;
               // Leaving at mid-stop-bit leaves half a bit of slack so a
               // start bit right after the stop bit is not missed.
               if (cnt == BIT_M1) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (rx_s) begin
                     data  <= shift;
                     valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ascii_rx.sv
// tb_uart_ascii_rx
// Self-checking bench for uart_ascii_rx at 16 clocks per bit. A frame task
// drives rx on falling clock edges and pushes the expected byte of every good
// frame into exp_q; a monitor pops and compares on each valid pulse.
module tb_uart_ascii_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   logic [7:0] exp_q[$];
   int checks;
   int errors;
   int valid_seen;
   int ferr_seen;
   logic prev_valid;
   logic prev_ferr;

   uart_ascii_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver: one 8N1 frame, LSB first; cut>0 releases the line high after
   // that many cycles and abandons the frame
   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int cut);
      int pos;
      if (stop_val && cut == 0) exp_q.push_back(b);
      for (int c = 0; c < 10 * CPB; c++) begin
         if (cut != 0 && c == cut) begin
            @(negedge clk);
            rx = 1'b1;
            return;
         end
         pos = c / CPB;
         @(negedge clk);
         if (pos == 0)      rx = 1'b0;
         else if (pos <= 8) rx = b[pos-1];
         else               rx = stop_val;
      end
   endtask

   task automatic idle_line(input int n);
      @(negedge clk);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) begin
            valid_seen++;
            check("busy_at_valid", busy, 0);
            if (prev_valid) check("valid_width", 2, 1);
            if (exp_q.size() == 0) check("unexpected_valid", {24'h0, data}, 32'hdead);
            else check("data", data, exp_q.pop_front());
         end
         if (frame_err) begin
            ferr_seen++;
            if (prev_ferr) check("ferr_width", 2, 1);
         end
      end
      prev_valid = valid;
      prev_ferr  = frame_err;
   end

   initial begin
      int v0, f0;
      logic [7:0] msg[6];
      checks = 0; errors = 0; valid_seen = 0; ferr_seen = 0;
      prev_valid = 1'b0; prev_ferr = 1'b0;
      msg = '{8'h31, 8'h32, 8'h2B, 8'h32, 8'h34, 8'h3D};
      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_data", data, 8'h00);
      check("rst_valid", valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_busy", busy, 0);
      idle_line(5);

      // single byte '1' with busy observed mid-frame
      v0 = valid_seen; f0 = ferr_seen;
      fork
         send_frame(8'h31, 1'b1, 0);
         begin
            repeat (40) @(negedge clk);
            check("busy_mid", busy, 1);
         end
      join
      idle_line(4);
      check("busy_after", busy, 0);
      wait_drain();
      check("one_valid", valid_seen - v0, 1);
      check("one_ferr", ferr_seen - f0, 0);

      // back-to-back "12+24=" with no gap
      v0 = valid_seen;
      for (int i = 0; i < 6; i++) send_frame(msg[i], 1'b1, 0);
      idle_line(10);
      wait_drain();
      check("b2b_count", valid_seen - v0, 6);

      // glitch: 3 low cycles
      v0 = valid_seen; f0 = ferr_seen;
      @(negedge clk); rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2 + HALF + 3) @(negedge clk);
      check("glitch_idle", busy, 0);
      idle_line(10);
      check("glitch_valid", valid_seen - v0, 0);
      check("glitch_ferr", ferr_seen - f0, 0);
      send_frame(8'h63, 1'b1, 0);
      idle_line(5);
      wait_drain();

      // bad stop bit; line idles high afterwards so the low stop is not a start
      v0 = valid_seen; f0 = ferr_seen;
      send_frame(8'h2A, 1'b0, 0);
      idle_line(40);
      check("badstop_ferr", ferr_seen - f0, 1);
      check("badstop_valid", valid_seen - v0, 0);
      check("badstop_data_held", data, 8'h63);
      send_frame(8'h2F, 1'b1, 0);
      idle_line(5);
      wait_drain();

      // reset during bit 4 of 0x39
      v0 = valid_seen; f0 = ferr_seen;
      fork
         send_frame(8'h39, 1'b1, 4 * CPB + CPB + 10);
         begin
            repeat (4 * CPB + CPB + 4) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            check("midrst_data", data, 8'h00);
            check("midrst_valid", valid, 0);
            check("midrst_ferr", frame_err, 0);
            check("midrst_busy", busy, 0);
         end
      join
      idle_line(30);
      check("midrst_no_pulse", (valid_seen - v0) + (ferr_seen - f0), 0);
      send_frame(8'h35, 1'b1, 0);
      idle_line(5);
      wait_drain();
      check("after_rst_data", data, 8'h35);

      // boundaries and random bytes
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
      idle_line(5);
      wait_drain();
      check("last_data_rand_done", exp_q.size(), 0);

      // long idle
      v0 = valid_seen; f0 = ferr_seen;
      idle_line(1000);
      check("idle_valid", valid_seen - v0, 0);
      check("idle_ferr", ferr_seen - f0, 0);
      check("idle_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
